// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding, BCD geometry and
// the packed-BCD helpers used by both the counter and the controller.
package stopwatch_ctrl_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = DIGIT_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  // Decimal +1 on a packed BCD word; a full 99999999 rolls to all zeros.
  function automatic logic [BCD_W-1:0] bcd_inc_val(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] res;
    logic             carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (res[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
          res[i*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          res[i*DIGIT_W +: DIGIT_W] = res[i*DIGIT_W +: DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return res;
  endfunction

  function automatic logic bcd_all_nines(input logic [BCD_W-1:0] v);
    logic nines;
    nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] != 4'd9) begin
        nines = 1'b0;
      end else begin
        nines = nines;
      end
    end
    return nines;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_counter8.sv
// Eight-digit packed-BCD counter; wrap flags the 99999999 -> 0 increment
// combinationally so the owner can latch overflow on the same edge.
module bcd_counter8
  import stopwatch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] count,
  output logic             wrap
);

  logic [BCD_W-1:0] r_count;

  assign wrap  = inc & ~clr & bcd_all_nines(r_count);
  assign count = r_count;

  // Counter register: clear has priority over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= bcd_inc_val(r_count);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, run/pause/lap FSM, tick
// prescaler, lap capture and the display mux around a BCD counter.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [31:0] count,
  output logic [31:0] display,
  output logic [1:0]  state,
  output logic        overflow
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  sw_state_e        r_state;
  logic             r_start_q, r_lap_q, r_clear_q;
  logic [PW-1:0]    r_presc;
  logic [BCD_W-1:0] r_lap;
  logic [BCD_W-1:0] r_display;
  logic             r_overflow;

  logic             w_start_ev, w_lap_ev, w_clear_ev;
  logic             w_inc, w_clr, w_wrap;
  logic [BCD_W-1:0] w_count, w_count_nxt;

  assign w_start_ev = btn_start & ~r_start_q;
  assign w_lap_ev   = btn_lap & ~r_lap_q;
  assign w_clear_ev = btn_clear & ~r_clear_q;

  assign w_inc = ((r_state == ST_RUN) || (r_state == ST_LAP)) && (r_presc == PRESC_MAX);
  // Clear only acts from PAUSE and loses to a coincident start or lap.
  assign w_clr = (r_state == ST_PAUSE) && w_clear_ev && !w_start_ev && !w_lap_ev;

  bcd_counter8 u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_inc),
    .clr     (w_clr),
    .count   (w_count),
    .wrap    (w_wrap)
  );

  // Value the counter will hold after this edge, so display can be registered.
  always_comb begin
    w_count_nxt = w_count;
    if (w_clr) begin
      w_count_nxt = '0;
    end else if (w_inc) begin
      w_count_nxt = bcd_inc_val(w_count);
    end else begin
      w_count_nxt = w_count;
    end
  end

  // Previous-sample registers; preset high so buttons held through reset stay quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q <= 1'b1;
      r_lap_q   <= 1'b1;
      r_clear_q <= 1'b1;
    end else begin
      r_start_q <= btn_start;
      r_lap_q   <= btn_lap;
      r_clear_q <= btn_clear;
    end
  end

  // Tick prescaler: runs in RUN/LAP, holds in PAUSE, parked at zero in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else begin
      case (r_state)
        ST_RUN, ST_LAP: r_presc <= w_inc ? '0 : r_presc + 1'b1;
        ST_PAUSE:       r_presc <= w_clr ? '0 : r_presc;
        default:        r_presc <= '0;
      endcase
    end
  end

  // Sticky overflow, dropped only by a clear back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_clr) begin
      r_overflow <= 1'b0;
    end else if (w_wrap) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Main FSM with lap capture and registered display selection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_lap     <= '0;
      r_display <= '0;
    end else begin
      r_display <= w_count_nxt;
      case (r_state)
        ST_IDLE: begin
          r_state <= w_start_ev ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (w_start_ev) begin
            r_state <= ST_PAUSE;
          end else if (w_lap_ev) begin
            r_state   <= ST_LAP;
            r_lap     <= w_count;
            r_display <= w_count;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_LAP: begin
          if (w_start_ev) begin
            r_state <= ST_PAUSE;
          end else if (w_lap_ev) begin
            r_state <= ST_RUN;
          end else begin
            r_state   <= ST_LAP;
            r_display <= r_lap;
          end
        end
        ST_PAUSE: begin
          if (w_start_ev) begin
            r_state <= ST_RUN;
          end else if (w_clr) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_PAUSE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign count    = w_count;
  assign display  = r_display;
  assign state    = r_state;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4: a decimal reference
// model feeds a scoreboard every cycle, plus table rows and corner sequences.
module tb_stopwatch_ctrl;

  localparam int TD   = 4;
  localparam int MAXV = 99999999;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_lap   = 1'b0;
  logic        btn_clear = 1'b0;
  logic [31:0] count, display;
  logic [1:0]  state;
  logic        overflow;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .btn_clear (btn_clear),
    .count     (count),
    .display   (display),
    .state     (state),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [31:0] disp;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic       s;
    logic       l;
    logic       c;
    int         idle;
    logic [1:0] st;
    int         cnt;
    int         disp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_state, m_cnt, m_lap, m_presc;
  logic m_ovf, m_ps, m_pl, m_pc;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = 32'd0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic has_hex(input logic [31:0] v);
    logic h;
    h = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] > 4'd9) h = 1'b1;
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_lap = 0; m_presc = 0;
    m_ovf = 1'b0; m_ps = 1'b1; m_pl = 1'b1; m_pc = 1'b1;
  endtask

  // Behavioural reference: one call per rising edge with that cycle's buttons.
  task automatic model_step(input logic s, input logic l, input logic c);
    logic es, el, ec, inc, clr;
    int   ns;
    es  = s && !m_ps;
    el  = l && !m_pl;
    ec  = c && !m_pc;
    inc = (m_state == 1 || m_state == 3) && (m_presc == TD - 1);
    clr = (m_state == 2) && ec && !es && !el;
    ns  = m_state;
    case (m_state)
      0: if (es) ns = 1;
      1: if (es) ns = 2; else if (el) begin ns = 3; m_lap = m_cnt; end
      3: if (es) ns = 2; else if (el) ns = 1;
      default: if (es) ns = 1; else if (clr) ns = 0;
    endcase
    if (m_state == 1 || m_state == 3) m_presc = inc ? 0 : m_presc + 1;
    else if (m_state == 2)            m_presc = clr ? 0 : m_presc;
    else                              m_presc = 0;
    if (clr) begin
      m_cnt = 0; m_ovf = 1'b0;
    end else if (inc) begin
      if (m_cnt == MAXV) begin m_cnt = 0; m_ovf = 1'b1; end
      else m_cnt = m_cnt + 1;
    end
    m_state = ns;
    m_ps = s; m_pl = l; m_pc = c;
  endtask

  // Drive one cycle from a negedge, queue the expectation, compare after the edge.
  task automatic step(input logic s, input logic l, input logic c);
    exp_t e;
    btn_start = s; btn_lap = l; btn_clear = c;
    model_step(s, l, c);
    e.st   = 2'(m_state);
    e.cnt  = to_bcd(m_cnt);
    e.disp = (m_state == 3) ? to_bcd(m_lap) : to_bcd(m_cnt);
    e.ovf  = m_ovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_state",    {30'd0, state},    {30'd0, e.st});
    chk("sb_count",    count,             e.cnt);
    chk("sb_display",  display,           e.disp);
    chk("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] bcd, input int dec);
    force dut.u_bcd.r_count = bcd;
    #1;
    release dut.u_bcd.r_count;
    m_cnt = dec;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 40, 2'd1, 10, 10};
    vecs[1]  = '{1'b1, 1'b0, 1'b0,  5, 2'd2, 10, 10};
    vecs[2]  = '{1'b1, 1'b0, 1'b0,  2, 2'd1, 10, 10};
    vecs[3]  = '{1'b0, 1'b1, 1'b0,  0, 2'd3, 11, 10};
    vecs[4]  = '{1'b0, 1'b0, 1'b1,  8, 2'd3, 13, 10};
    vecs[5]  = '{1'b0, 1'b1, 1'b0,  1, 2'd1, 13, 13};
    vecs[6]  = '{1'b1, 1'b1, 1'b0,  1, 2'd2, 14, 14};
    vecs[7]  = '{1'b0, 1'b1, 1'b0,  1, 2'd2, 14, 14};
    vecs[8]  = '{1'b0, 1'b1, 1'b1,  1, 2'd2, 14, 14};
    vecs[9]  = '{1'b0, 1'b0, 1'b1,  1, 2'd0,  0,  0};
    vecs[10] = '{1'b0, 1'b1, 1'b1,  2, 2'd0,  0,  0};

    #1 reset_n = 1'b0;
    #10;
    chk("rst_state",    {30'd0, state},    32'd0);
    chk("rst_count",    count,             32'd0);
    chk("rst_display",  display,           32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].s, vecs[i].l, vecs[i].c);
      for (int k = 0; k < vecs[i].idle; k++) step(1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_state", i),   {30'd0, state}, {30'd0, vecs[i].st});
      chk($sformatf("vec%0d_count", i),   count,          to_bcd(vecs[i].cnt));
      chk($sformatf("vec%0d_display", i), display,        to_bcd(vecs[i].disp));
    end

    // Lap freeze at 3, keep counting underneath, release shows live count.
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b0);
    chk("lap_pre_count", count, 32'h00000003);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b0);
    chk("lap_frozen_display", display, 32'h00000003);
    chk("lap_live_count",     count,   32'h00000006);
    step(1'b0, 1'b1, 1'b0);
    chk("lap_release_display", display,        32'h00000006);
    chk("lap_release_state",   {30'd0, state}, 32'd1);

    // Decimal carry across two digits.
    preload(32'h00000099, 99);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("carry_nohex_count",   {31'd0, has_hex(count)},   32'd0);
      chk("carry_nohex_display", {31'd0, has_hex(display)}, 32'd0);
      if (count != 32'h00000099) break;
    end
    chk("carry_count", count, 32'h00000100);

    // Full wrap sets overflow; only a clear from PAUSE drops it.
    preload(32'h99999999, MAXV);
    prev = count;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (count != prev) break;
    end
    chk("wrap_count",    count,             32'd0);
    chk("wrap_overflow", {31'd0, overflow}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("pause_keeps_overflow", {31'd0, overflow}, 32'd1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("clear_state",    {30'd0, state},    32'd0);
    chk("clear_overflow", {31'd0, overflow}, 32'd0);
    chk("clear_count",    count,             32'd0);

    // Start held through reset release produces no event.
    btn_start = 1'b1;
    reset_n   = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    chk("held_start_state", {30'd0, state}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0);
    chk("midrun_count", count, 32'h00000002);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_state",    {30'd0, state},    32'd0);
    chk("async_rst_count",    count,             32'd0);
    chk("async_rst_display",  display,           32'd0);
    chk("async_rst_overflow", {31'd0, overflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clock cycles per BCD increment, legal range 2..2^20.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port btn_start  in  1  start/stop request, level, synchronous to clk, already debounced.
REQ-005 SHALL have port btn_lap  in  1  lap freeze/release request, level, synchronous, already debounced.
REQ-006 SHALL have port btn_clear  in  1  clear request, level, synchronous, already debounced.
REQ-007 SHALL have port count  out  32  live 8-digit packed BCD, digit 0 in [3:0].
REQ-008 SHALL have port display  out  32  BCD value for the display path.
REQ-009 SHALL have port state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-010 SHALL have port overflow  out  1  sticky flag, set on 99999999->0 wrap.

Function
REQ-011 Each button SHALL produce a one-cycle event when the current sample is 1 and the previous registered sample is 0.
REQ-012 When events coincide in one cycle, start SHALL win; lap beats clear; losing events are dropped.
REQ-013 IDLE SHALL go to RUN on start; lap and clear SHALL be ignored.
REQ-014 RUN SHALL go to PAUSE on start and to LAP on lap; clear SHALL be ignored.
REQ-015 LAP SHALL go to PAUSE on start and to RUN on lap; clear SHALL be ignored.
REQ-016 PAUSE SHALL go to RUN on start and to IDLE on clear; lap SHALL be ignored.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 in RUN and LAP, hold in PAUSE, and be 0 in IDLE.
REQ-018 An increment SHALL occur on the edge where the prescaler wraps from TICK_DIV-1 to 0.
REQ-019 The first increment SHALL occur exactly TICK_DIV cycles after the edge that enters RUN from IDLE.
REQ-020 Each increment SHALL add one in decimal: digit 9 becomes 0 with carry into the next digit; digits never hold A-F.
REQ-021 99999999 plus one SHALL give 00000000 and set overflow in the same edge.
REQ-022 Entering IDLE via clear SHALL zero count, prescaler and overflow on that edge.
REQ-023 Entering LAP SHALL capture count into the lap register, using the pre-increment value if an increment coincides.
REQ-024 display SHALL show the lap register in LAP and count in every other state.
REQ-025 Leaving LAP SHALL make display follow count from the next cycle.
REQ-026 Counting SHALL continue while in LAP.

Reset
REQ-027 While reset_n=0, state SHALL be IDLE; count, display, lap register, prescaler and overflow SHALL be 0.
REQ-028 While reset_n=0, the previous-sample button registers SHALL be 1, so buttons held through reset release produce no event.
REQ-029 Reset asserted mid-count SHALL clear everything asynchronously, without waiting for a clk edge.

Structure
REQ-030 A shared package SHALL hold the state encoding constants and the BCD digit width (4) and digit count (8).
REQ-031 The BCD incrementer SHALL be a sub-module bcd_counter8 with ports clk, reset_n, inc, clr, count[31:0], wrap.
REQ-032 The FSM, edge detectors, prescaler and lap register SHALL reside in stopwatch_ctrl.

Verification (TICK_DIV=4)
REQ-033 Pulse start from IDLE, run 40 cycles -> count=00000010 and state=RUN.
REQ-034 Start, lap at count 00000003, run 12 more cycles -> display=00000003 and count=00000006; lap again -> display=00000006 next cycle.
REQ-035 Preload count 00000099 via force, run until the next increment -> count=00000100 with no hex digits at any step.
REQ-036 Count at 99999999 in RUN, next increment -> count=0 and overflow=1; start then clear -> state=IDLE, overflow=0.
REQ-037 Assert start and lap in the same cycle from RUN -> state=PAUSE and display=count.
REQ-038 Hold btn_start=1 across reset release -> state stays IDLE; drop reset_n mid-RUN -> all outputs 0 immediately.
